// File: rtl/user_stream_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : user_stream_rr_arbiter
// Description : Packet-granular round-robin merge of two AXI4SR streams into
//               one; output tid carries the source index in its MSB.
// Revision    : 1.0
// ============================================================================
module user_stream_rr_arbiter #(
  parameter int DATA_BITS = 512,
  parameter int TID_BITS  = 6,
  parameter int CNT_BITS  = 32
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    s0_tvalid,
  output logic                    s0_tready,
  input  logic [DATA_BITS-1:0]    s0_tdata,
  input  logic [DATA_BITS/8-1:0]  s0_tkeep,
  input  logic                    s0_tlast,
  input  logic [TID_BITS-1:0]     s0_tid,
  input  logic                    s1_tvalid,
  output logic                    s1_tready,
  input  logic [DATA_BITS-1:0]    s1_tdata,
  input  logic [DATA_BITS/8-1:0]  s1_tkeep,
  input  logic                    s1_tlast,
  input  logic [TID_BITS-1:0]     s1_tid,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic [DATA_BITS-1:0]    m_tdata,
  output logic [DATA_BITS/8-1:0]  m_tkeep,
  output logic                    m_tlast,
  output logic [TID_BITS:0]       m_tid,
  input  logic [1:0]              en_mask,
  output logic                    busy,
  output logic [CNT_BITS-1:0]     pkt_cnt_0,
  output logic [CNT_BITS-1:0]     pkt_cnt_1
);

  localparam logic [CNT_BITS-1:0] c_cnt_one = CNT_BITS'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOCK0 = 2'd1,
    ST_LOCK1 = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   r_rr_ptr;
  logic   w_rr_ptr_nxt;
  logic [1:0] w_req;
  logic   w_out_free;
  logic   w_acc0;
  logic   w_acc1;
  logic   w_end0;
  logic   w_end1;

  // en_mask only matters here; a locked packet ignores it until tlast
  assign w_req      = {s1_tvalid & en_mask[1], s0_tvalid & en_mask[0]};
  assign w_out_free = !m_tvalid | m_tready;
  assign s0_tready  = (r_state == ST_LOCK0) & w_out_free;
  assign s1_tready  = (r_state == ST_LOCK1) & w_out_free;
  assign w_acc0     = s0_tvalid & s0_tready;
  assign w_acc1     = s1_tvalid & s1_tready;
  assign w_end0     = w_acc0 & s0_tlast;
  assign w_end1     = w_acc1 & s1_tlast;
  assign busy       = (r_state != ST_IDLE);

  always_comb begin
    w_state_nxt  = r_state;
    w_rr_ptr_nxt = r_rr_ptr;
    case (r_state)
      ST_IDLE: begin
        case (w_req)
          2'b01:   w_state_nxt = ST_LOCK0;
          2'b10:   w_state_nxt = ST_LOCK1;
          2'b11:   w_state_nxt = r_rr_ptr ? ST_LOCK1 : ST_LOCK0;
          default: w_state_nxt = ST_IDLE;
        endcase
      end
      ST_LOCK0: begin
        if (w_end0) begin
          w_state_nxt  = ST_IDLE;
          w_rr_ptr_nxt = 1'b1;
        end
      end
      ST_LOCK1: begin
        if (w_end1) begin
          w_state_nxt  = ST_IDLE;
          w_rr_ptr_nxt = 1'b0;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state  <= ST_IDLE;
      r_rr_ptr <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
    end
  end

  // Output register: loads on acceptance, otherwise holds until drained
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
      m_tkeep  <= '0;
      m_tlast  <= 1'b0;
      m_tid    <= '0;
    end else if (w_acc1) begin
      m_tvalid <= 1'b1;
      m_tdata  <= s1_tdata;
      m_tkeep  <= s1_tkeep;
      m_tlast  <= s1_tlast;
      m_tid    <= {1'b1, s1_tid};
    end else if (w_acc0) begin
      m_tvalid <= 1'b1;
      m_tdata  <= s0_tdata;
      m_tkeep  <= s0_tkeep;
      m_tlast  <= s0_tlast;
      m_tid    <= {1'b0, s0_tid};
    end else if (m_tready) begin
      m_tvalid <= 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pkt_cnt_0 <= '0;
      pkt_cnt_1 <= '0;
    end else begin
      if (w_end0) pkt_cnt_0 <= pkt_cnt_0 + c_cnt_one;
      if (w_end1) pkt_cnt_1 <= pkt_cnt_1 + c_cnt_one;
    end
  end

endmodule
`default_nettype wire
